// File: rtl/mmu_sequencer.sv
// mmu_sequencer: loads 4 weights + 4 inputs into operand memory, runs mmu_feeder, then returns 4 results.
// Latency: write is combinational with the accepted beat; COMPUTE lasts COMPUTE_LEN cycles; then one result per handshake.
// Backpressure: host stalls freely in LOAD states, out_ready low freezes OUTPUT; optional MMU_SEQ_WEIGHT_REUSE_EN adds keep_w.
module mmu_sequencer #(
    parameter int COMPUTE_LEN = 6,
    parameter int N_OPS       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       host_valid,
    input  logic [7:0] host_data,
    output logic       host_ready,
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
    input  logic       keep_w,
`endif
    output logic       mem_we,
    output logic       mem_sel,
    output logic [1:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       feeder_en,
    output logic [2:0] compute_cycles,
    output logic [1:0] output_sel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LOAD_I  = 3'd2,
        COMPUTE = 3'd3,
        OUTPUT  = 3'd4
    } state_t;

    localparam logic [1:0] OPS_LAST = 2'(N_OPS - 1);
    localparam logic [2:0] CC_LAST  = 3'(COMPUTE_LEN - 1);
    localparam logic [2:0] CC_DONE  = 3'(COMPUTE_LEN);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] cnt;
    logic [2:0] cc;
    logic [1:0] sel;
    logic       accept;
    logic       beat_last;
    logic       out_hs;
    logic       reuse_w;

`ifdef MMU_SEQ_WEIGHT_REUSE_EN
    logic w_loaded;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            w_loaded <= 1'b0;
        else if (state == LOAD_W && state_nxt == LOAD_I)
            w_loaded <= 1'b1;
    end

    assign reuse_w = keep_w & w_loaded;
`else
    assign reuse_w = 1'b0;
`endif

    assign accept    = host_valid & host_ready;
    assign beat_last = (cnt == OPS_LAST);
    assign out_hs    = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = reuse_w ? LOAD_I : LOAD_W;
            LOAD_W:  if (accept && beat_last) state_nxt = LOAD_I;
            LOAD_I:  if (accept && beat_last) state_nxt = COMPUTE;
            COMPUTE: if (cc == CC_LAST) state_nxt = OUTPUT;
            OUTPUT:  if (out_hs && sel == 2'd3) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // host_ready is gated by rst_n so nothing is accepted or written while reset is held
    always_comb begin
        host_ready = 1'b0;
        mem_we     = 1'b0;
        mem_sel    = 1'b0;
        mem_addr   = 2'd0;
        mem_wdata  = host_data;
        feeder_en  = 1'b0;
        out_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                host_ready = rst_n;
                mem_sel    = reuse_w;
            end
            LOAD_W: begin
                host_ready = rst_n;
                mem_addr   = cnt;
            end
            LOAD_I: begin
                host_ready = rst_n;
                mem_sel    = 1'b1;
                mem_addr   = cnt;
            end
            COMPUTE: feeder_en = 1'b1;
            OUTPUT: begin
                feeder_en = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
        mem_we = accept;
    end

    // The first beat is taken in IDLE as index 0, so the bank continues at index 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= 2'd0;
        else if (accept) begin
            if (state == IDLE)
                cnt <= 2'd1;
            else if (beat_last)
                cnt <= 2'd0;
            else
                cnt <= cnt + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc  <= 3'd0;
            sel <= 2'd0;
        end else begin
            if (state == COMPUTE && cc != CC_DONE)
                cc <= cc + 3'd1;
            if (state == OUTPUT && out_hs) begin
                sel <= sel + 2'd1;
                if (sel == 2'd3)
                    cc <= 3'd0;
            end
        end
    end

    assign compute_cycles = cc;
    assign output_sel     = sel;

endmodule

// File: tb/tb_mmu_sequencer.sv
// Directed bench for mmu_sequencer: logs operand writes, models the 2x2 product and checks results per output_sel.
module tb_mmu_sequencer;

    localparam int CLEN = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_valid = 1'b0;
    logic [7:0] host_data = 8'd0;
    logic       out_ready = 1'b0;
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
    logic       keep_w = 1'b0;
`endif
    logic       host_ready;
    logic       mem_we;
    logic       mem_sel;
    logic [1:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       feeder_en;
    logic [2:0] compute_cycles;
    logic [1:0] output_sel;
    logic       out_valid;
    logic       busy;

    mmu_sequencer #(.COMPUTE_LEN(CLEN), .N_OPS(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host_valid     (host_valid),
        .host_data      (host_data),
        .host_ready     (host_ready),
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
        .keep_w         (keep_w),
`endif
        .mem_we         (mem_we),
        .mem_sel        (mem_sel),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .feeder_en      (feeder_en),
        .compute_cycles (compute_cycles),
        .output_sel     (output_sel),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Operand memory stand-in and write log
    logic [7:0]  mem [2][4];
    logic [10:0] wlog [64];
    int          wr_total = 0;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_sel][mem_addr] = mem_wdata;
            wlog[wr_total % 64] = {mem_sel, mem_addr, mem_wdata};
            wr_total++;
        end
    end

    // Result of W(2x2) x I(2x2), row-major, as mmu_feeder would present at output_sel s
    function automatic int res(input int s);
        int r = s / 2;
        int c = s % 2;
        return int'(mem[0][r*2]) * int'(mem[1][c]) + int'(mem[0][r*2+1]) * int'(mem[1][2+c]);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_host_ready"}, host_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_feeder_en"}, feeder_en, 0);
        check({tag, "_cc"}, compute_cycles, 0);
        check({tag, "_output_sel"}, output_sel, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_mem_we"}, mem_we, 0);
    endtask

    task automatic send_beat(input logic [7:0] d, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            host_valid = 1'b0;
        end
        @(negedge clk);
        host_valid = 1'b1;
        host_data  = d;
        t = 0;
        while (!host_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("beat_ready", host_ready, 1);
        @(posedge clk);
    endtask

    // Loads n beats, then checks the write log and the COMPUTE phase; returns at the first OUTPUT negedge
    task automatic load_job(input logic [63:0] b, input int n, input int gap, input bit hold, input string tag);
        int          base;
        logic [10:0] exp_w;
        base = wr_total;
        for (int i = 0; i < n; i++)
            send_beat(b[63-8*i -: 8], gap);
        @(negedge clk);
        host_valid = hold;
        host_data  = 8'hFF;
        check({tag, "_wr_count"}, wr_total - base, n);
        for (int j = 0; j < n; j++) begin
            exp_w = {(n == 4) ? 1'b1 : (j >= 4), 2'(j % 4), b[63-8*j -: 8]};
            check({tag, "_wr_log"}, wlog[(base + j) % 64], exp_w);
        end
        for (int c = 0; c < CLEN; c++) begin
            #1;
            check({tag, "_cc"}, compute_cycles, c);
            check({tag, "_cmp_en"}, feeder_en, 1);
            check({tag, "_cmp_ready"}, host_ready, 0);
            check({tag, "_cmp_we"}, mem_we, 0);
            @(negedge clk);
        end
        check({tag, "_cc_hold"}, compute_cycles, CLEN);
        check({tag, "_out_valid"}, out_valid, 1);
    endtask

    task automatic read_results(input logic [31:0] e, input int stall_sel, input int stall_n, input string tag);
        out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            #1;
            check({tag, "_ov"}, out_valid, 1);
            check({tag, "_sel"}, output_sel, s);
            check({tag, "_en"}, feeder_en, 1);
            check({tag, "_ready"}, host_ready, 0);
            check({tag, "_result"}, res(s), e[31-8*s -: 8]);
            if (s == stall_sel) begin
                out_ready = 1'b0;
                repeat (stall_n) @(negedge clk);
                check({tag, "_stall_sel"}, output_sel, s);
                check({tag, "_stall_ov"}, out_valid, 1);
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        out_ready  = 1'b0;
        host_valid = 1'b0;
        check({tag, "_end_busy"}, busy, 0);
        check({tag, "_end_ov"}, out_valid, 0);
        check({tag, "_end_en"}, feeder_en, 0);
        check({tag, "_end_sel"}, output_sel, 0);
        check({tag, "_end_cc"}, compute_cycles, 0);
        check({tag, "_end_ready"}, host_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int base;

    initial begin
        #2;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_ready", host_ready, 1);

        // Abandon a job after 6 beats
        for (int i = 0; i < 6; i++)
            send_beat(8'(i + 1), 0);
        @(negedge clk);
        host_valid = 1'b0;
        #1;
        check("mid_busy", busy, 1);
        check("mid_sel", mem_sel, 1);
        check("mid_addr", mem_addr, 2);
        base = wr_total;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_no_wr", wr_total - base, 0);

        load_job(64'h01020304_05060708, 8, 0, 1'b0, "job1");
        read_results({8'd19, 8'd22, 8'd43, 8'd50}, -1, 0, "job1");

        load_job(64'h01020304_05060708, 8, 3, 1'b0, "gap");
        read_results({8'd19, 8'd22, 8'd43, 8'd50}, 2, 10, "gap");

        base = wr_total;
        load_job(64'h01020304_05060708, 8, 0, 1'b1, "hold");
        read_results({8'd19, 8'd22, 8'd43, 8'd50}, -1, 0, "hold");
        @(negedge clk);
        check("hold_wr_total", wr_total - base, 8);
        check("hold_idle_busy", busy, 0);

`ifdef MMU_SEQ_WEIGHT_REUSE_EN
        keep_w = 1'b1;
        load_job(64'h01000001_00000000, 4, 0, 1'b0, "reuse");
        read_results({8'd1, 8'd2, 8'd3, 8'd4}, -1, 0, "reuse");
        keep_w = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
